// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data RAM behind a req/ack handshake with programmable wait states
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ack,
    output logic              err,
    output logic              busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    // Any address bit above the word index makes the access out of range.
    localparam logic [ADDR_W-1:0] HI_MASK  = ~(ADDR_W'((64'(1) << (IDX_W + 2)) - 64'(1)));

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [31:0]       mem_q [DEPTH];

    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_err;
    logic              enter_resp;
    logic              mem_we;
    logic [IDX_W-1:0]  wr_idx;

    // The response is computed on the edge that enters RESP; with zero wait
    // states that edge is the capture edge, so the live bus inputs are used.
    always_comb begin
        sel_addr = (state_q == S_IDLE) ? addr : addr_q;
        sel_we   = (state_q == S_IDLE) ? we : we_q;
        sel_idx  = sel_addr[IDX_W+1:2];
        sel_err  = (sel_addr[1:0] != 2'b00)
                || (int'(sel_idx) >= DEPTH)
                || ((sel_addr & HI_MASK) != '0);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rdata_d    = 32'h0;
        enter_resp = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = CNT_INIT;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (enter_resp) begin
            ack_d   = 1'b1;
            err_d   = sel_err;
            rdata_d = (sel_err || sel_we) ? 32'h0 : mem_q[sel_idx];
        end

        busy_d = (state_d != S_IDLE);
    end

    // Commit happens at the end of the RESP cycle; a reset on that edge aborts it.
    always_comb begin
        wr_idx = addr_q[IDX_W+1:2];
        mem_we = (state_q == S_RESP) && we_q && !err_q && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_idx] <= wdata_q;
        end
    end

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule
